k6502_seq: RTL and testbench

- Cycle and interrupt sequencer that drives the microcode decoder.
- Owns the one-hot cycle counter, the instruction register, and the {rst, nmi, irq} sequence-select lines the decoder consumes.
- Latches opcodes at end-of-instruction, detects NMI edges, arbitrates multiple maskable IRQ sources, and forces interrupt entry (IR = 8'h00).
- Supports a stall input and a jam/halt trap for microcode sequences that never assert SYNC.

---
 rtl/k6502_seq.sv | 140 ++++++++++++++
 tb/tb_k6502_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/k6502_seq.sv
// k6502_seq: cycle and interrupt sequencer feeding the microcode decoder.
//
// Owns the one-hot cycle counter, the instruction register and the
// {rst, nmi, irq} sequence-select lines. At every end-of-instruction (sync)
// it decides what runs next: a pending NMI, then the lowest-numbered enabled
// IRQ, then the opcode on din. Interrupt entry forces ir to 8'h00 (BRK).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rdy               1 = advance, 0 = stall (architectural state held)
//   sync              decoder end-of-instruction bit for the current cycle
//   din               data bus; opcode byte when sync=1
//   sr_i              processor I flag, masks all IRQ lines
//   nmi_n             non-maskable interrupt, active low, falling-edge
//   irq_n, irq_en     maskable requests (active low) and per-line enables
//   ir                instruction register
//   cycle             one-hot cycle, bit0 = first cycle after fetch
//   seq_rst/nmi/irq   sequence currently executing (at most one set)
//   irq_src           index of the last IRQ line taken
//   jam               cycle counter ran off the end without sync
//
// Handshake: there is no valid/ready pair; rdy is a plain advance enable
// sampled at each rising clk edge, and sync is only honoured when rdy=1 and
// jam=0.
module k6502_seq #(
  parameter int CYCLE_W   = 6,
  parameter int IRQ_N     = 4,
  parameter int IRQ_IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 sync,
  input  logic [7:0]           din,
  input  logic                 sr_i,
  input  logic                 nmi_n,
  input  logic [IRQ_N-1:0]     irq_n,
  input  logic [IRQ_N-1:0]     irq_en,
  output logic [7:0]           ir,
  output logic [CYCLE_W-1:0]   cycle,
  output logic                 seq_rst,
  output logic                 seq_nmi,
  output logic                 seq_irq,
  output logic [IRQ_IDX_W-1:0] irq_src,
  output logic                 jam
);

  localparam logic [CYCLE_W-1:0] CYCLE_FIRST = {{(CYCLE_W-1){1'b0}}, 1'b1};

  logic                 nmi_q;
  logic                 nmi_pend;
  logic                 nmi_edge;
  logic [IRQ_N-1:0]     req;
  logic [IRQ_IDX_W-1:0] req_idx;

  logic [7:0]           ir_d;
  logic [CYCLE_W-1:0]   cycle_d;
  logic                 seq_rst_d;
  logic                 seq_nmi_d;
  logic                 seq_irq_d;
  logic [IRQ_IDX_W-1:0] irq_src_d;
  logic                 jam_d;
  logic                 nmi_pend_d;

  // Falling edge: previous sample high, current input low.
  assign nmi_edge = nmi_q & ~nmi_n;

  assign req = ~irq_n & irq_en & {IRQ_N{~sr_i}};

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    req_idx = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (req[i]) req_idx = IRQ_IDX_W'(i);
    end
  end

  always_comb begin
    ir_d       = ir;
    cycle_d    = cycle;
    seq_rst_d  = seq_rst;
    seq_nmi_d  = seq_nmi;
    seq_irq_d  = seq_irq;
    irq_src_d  = irq_src;
    jam_d      = jam;
    // Edge detection keeps running through stalls and jam.
    nmi_pend_d = nmi_pend | nmi_edge;

    if (rdy && !jam) begin
      if (sync) begin
        cycle_d   = CYCLE_FIRST;
        seq_rst_d = 1'b0;
        seq_nmi_d = 1'b0;
        seq_irq_d = 1'b0;
        if (nmi_pend) begin
          ir_d       = 8'h00;
          seq_nmi_d  = 1'b1;
          // An edge seen this same cycle re-arms for the next sync.
          nmi_pend_d = nmi_edge;
        end else if (|req) begin
          ir_d      = 8'h00;
          seq_irq_d = 1'b1;
          irq_src_d = req_idx;
        end else begin
          ir_d = din;
        end
      end else if (cycle[CYCLE_W-1]) begin
        // No more cycles to give: trap and leave cycle parked on the MSB.
        jam_d = 1'b1;
      end else begin
        cycle_d = cycle << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir       <= 8'h00;
      cycle    <= CYCLE_FIRST;
      seq_rst  <= 1'b1;
      seq_nmi  <= 1'b0;
      seq_irq  <= 1'b0;
      irq_src  <= '0;
      jam      <= 1'b0;
      nmi_pend <= 1'b0;
      nmi_q    <= 1'b1;
    end else begin
      ir       <= ir_d;
      cycle    <= cycle_d;
      seq_rst  <= seq_rst_d;
      seq_nmi  <= seq_nmi_d;
      seq_irq  <= seq_irq_d;
      irq_src  <= irq_src_d;
      jam      <= jam_d;
      nmi_pend <= nmi_pend_d;
      nmi_q    <= nmi_n;
    end
  end

endmodule

// File: tb/tb_k6502_seq.sv
// Directed testbench for k6502_seq with default parameters
// (CYCLE_W=6, IRQ_N=4, IRQ_IDX_W=2). Inputs change 1ns after each rising
// edge, and outputs are checked at the same point, away from the edge.
module tb_k6502_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy;
  logic       sync;
  logic [7:0] din;
  logic       sr_i;
  logic       nmi_n;
  logic [3:0] irq_n;
  logic [3:0] irq_en;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       seq_rst;
  logic       seq_nmi;
  logic       seq_irq;
  logic [1:0] irq_src;
  logic       jam;

  int total = 0;
  int bad   = 0;

  k6502_seq #(.CYCLE_W(6), .IRQ_N(4), .IRQ_IDX_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdy     (rdy),
    .sync    (sync),
    .din     (din),
    .sr_i    (sr_i),
    .nmi_n   (nmi_n),
    .irq_n   (irq_n),
    .irq_en  (irq_en),
    .ir      (ir),
    .cycle   (cycle),
    .seq_rst (seq_rst),
    .seq_nmi (seq_nmi),
    .seq_irq (seq_irq),
    .irq_src (irq_src),
    .jam     (jam)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver: advance one rising edge, then settle 1ns past it.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rdy = 1'b1; sync = 1'b0; din = 8'h00; sr_i = 1'b0;
    nmi_n = 1'b1; irq_n = 4'b1111; irq_en = 4'b1111;
    tick(2);
    total++;
    if ({cycle, ir, seq_rst, seq_nmi, seq_irq, irq_src, jam} !== {6'b000001, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got cycle=%b ir=%h rst/nmi/irq=%b%b%b src=%0d jam=%b required 000001 00 100 0 0",
               cycle, ir, seq_rst, seq_nmi, seq_irq, irq_src, jam);
    end
    rst_n = 1'b1;
    tick(4);
    total++;
    if ({cycle, seq_rst} !== {6'b010000, 1'b1}) begin
      bad++;
      $display("FAIL reset_seq_bit4: got cycle=%b seq_rst=%b required 010000 1", cycle, seq_rst);
    end
    sync = 1'b1; din = 8'hA9;
    tick(1);
    sync = 1'b0;
    total++;
    if ({ir, cycle, seq_rst} !== {8'hA9, 6'b000001, 1'b0}) begin
      bad++;
      $display("FAIL reset_exit: got ir=%h cycle=%b seq_rst=%b required a9 000001 0", ir, cycle, seq_rst);
    end
  endtask

  task automatic test_two_cycle;
    sync = 1'b1; din = 8'h69;
    tick(1);
    total++;
    if ({ir, cycle} !== {8'h69, 6'b000001}) begin
      bad++;
      $display("FAIL two_cycle_load: got ir=%h cycle=%b required 69 000001", ir, cycle);
    end
    sync = 1'b0;
    tick(1);
    total++;
    if (cycle !== 6'b000010) begin
      bad++;
      $display("FAIL two_cycle_bit1: got cycle=%b required 000010", cycle);
    end
    sync = 1'b1; din = 8'hEA;
    tick(1);
    sync = 1'b0;
    total++;
    if ({ir, cycle} !== {8'hEA, 6'b000001}) begin
      bad++;
      $display("FAIL two_cycle_next: got ir=%h cycle=%b required ea 000001", ir, cycle);
    end
  endtask

  task automatic test_nmi_then_irq;
    irq_n = 4'b1011; irq_en = 4'b1111; sr_i = 1'b0;
    tick(1);
    nmi_n = 1'b0;
    tick(1);
    nmi_n = 1'b1;
    sync = 1'b1; din = 8'h55;
    tick(1);
    sync = 1'b0;
    total++;
    if ({ir, cycle, seq_rst, seq_nmi, seq_irq} !== {8'h00, 6'b000001, 3'b010}) begin
      bad++;
      $display("FAIL nmi_take: got ir=%h cycle=%b rst/nmi/irq=%b%b%b required 00 000001 010",
               ir, cycle, seq_rst, seq_nmi, seq_irq);
    end
    tick(1);
    sync = 1'b1; din = 8'h55;
    tick(1);
    total++;
    if ({ir, seq_nmi, seq_irq, irq_src} !== {8'h00, 1'b0, 1'b1, 2'd2}) begin
      bad++;
      $display("FAIL irq_after_nmi: got ir=%h nmi=%b irq=%b src=%0d required 00 0 1 2", ir, seq_nmi, seq_irq, irq_src);
    end
    irq_n = 4'b1111; din = 8'hEA;
    tick(1);
    sync = 1'b0;
    total++;
    if ({ir, seq_irq, irq_src} !== {8'hEA, 1'b0, 2'd2}) begin
      bad++;
      $display("FAIL irq_src_hold: got ir=%h irq=%b src=%0d required ea 0 2", ir, seq_irq, irq_src);
    end
  endtask

  task automatic test_irq_priority;
    irq_n = 4'b0101; irq_en = 4'b1111; sr_i = 1'b0;
    sync = 1'b1; din = 8'hA5;
    tick(1);
    total++;
    if ({ir, seq_irq, irq_src} !== {8'h00, 1'b1, 2'd1}) begin
      bad++;
      $display("FAIL irq_lowest: got ir=%h irq=%b src=%0d required 00 1 1", ir, seq_irq, irq_src);
    end
    sr_i = 1'b1; din = 8'hC8;
    tick(1);
    total++;
    if ({ir, seq_irq, irq_src} !== {8'hC8, 1'b0, 2'd1}) begin
      bad++;
      $display("FAIL irq_masked: got ir=%h irq=%b src=%0d required c8 0 1", ir, seq_irq, irq_src);
    end
    sr_i = 1'b0; irq_en = 4'b0000; din = 8'hE8;
    tick(1);
    sync = 1'b0;
    total++;
    if ({ir, seq_irq} !== {8'hE8, 1'b0}) begin
      bad++;
      $display("FAIL irq_disabled: got ir=%h irq=%b required e8 0", ir, seq_irq);
    end
    irq_n = 4'b1111; irq_en = 4'b1111;
  endtask

  task automatic test_stall;
    tick(1);
    rdy = 1'b0; sync = 1'b1; din = 8'h11;
    nmi_n = 1'b0;
    tick(1);
    nmi_n = 1'b1;
    tick(2);
    total++;
    if ({cycle, ir, seq_nmi} !== {6'b000010, 8'hE8, 1'b0}) begin
      bad++;
      $display("FAIL stall_hold: got cycle=%b ir=%h nmi=%b required 000010 e8 0", cycle, ir, seq_nmi);
    end
    rdy = 1'b1; din = 8'h4C;
    tick(1);
    total++;
    if ({ir, cycle, seq_nmi} !== {8'h00, 6'b000001, 1'b1}) begin
      bad++;
      $display("FAIL stall_nmi_take: got ir=%h cycle=%b nmi=%b required 00 000001 1", ir, cycle, seq_nmi);
    end
    din = 8'hEA;
    tick(1);
    sync = 1'b0;
    total++;
    if ({ir, seq_nmi} !== {8'hEA, 1'b0}) begin
      bad++;
      $display("FAIL nmi_pend_cleared: got ir=%h nmi=%b required ea 0", ir, seq_nmi);
    end
  endtask

  task automatic test_back_to_back;
    // NMI edge in the same cycle as sync waits for the following sync.
    sync = 1'b1; din = 8'h18; nmi_n = 1'b0;
    tick(1);
    nmi_n = 1'b1;
    total++;
    if ({ir, seq_nmi} !== {8'h18, 1'b0}) begin
      bad++;
      $display("FAIL nmi_same_cycle: got ir=%h nmi=%b required 18 0", ir, seq_nmi);
    end
    din = 8'h38;
    tick(1);
    total++;
    if ({ir, seq_nmi} !== {8'h00, 1'b1}) begin
      bad++;
      $display("FAIL nmi_deferred: got ir=%h nmi=%b required 00 1", ir, seq_nmi);
    end
    din = 8'hEA;
    tick(1);
    sync = 1'b0;
  endtask

  task automatic test_jam;
    tick(5);
    total++;
    if ({cycle, jam} !== {6'b100000, 1'b0}) begin
      bad++;
      $display("FAIL jam_msb: got cycle=%b jam=%b required 100000 0", cycle, jam);
    end
    tick(1);
    total++;
    if ({cycle, jam} !== {6'b100000, 1'b1}) begin
      bad++;
      $display("FAIL jam_set: got cycle=%b jam=%b required 100000 1", cycle, jam);
    end
    sync = 1'b1; din = 8'hA9;
    tick(2);
    sync = 1'b0;
    total++;
    if ({cycle, ir, jam} !== {6'b100000, 8'hEA, 1'b1}) begin
      bad++;
      $display("FAIL jam_frozen: got cycle=%b ir=%h jam=%b required 100000 ea 1", cycle, ir, jam);
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    total++;
    if ({jam, cycle, seq_rst, ir} !== {1'b0, 6'b000001, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL jam_reset: got jam=%b cycle=%b seq_rst=%b ir=%h required 0 000001 1 00", jam, cycle, seq_rst, ir);
    end
  endtask

  initial begin
    test_reset();
    test_two_cycle();
    test_nmi_then_irq();
    test_irq_priority();
    test_stall();
    test_back_to_back();
    test_jam();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
